// File: rtl/cache_pkg.sv
// Shared definitions for the cache/memory arbiter.
//
// Contents:
//   LINE_BYTES  - bytes per cache line. Fill and writeback commands are
//                 aligned to this size.
//   BEATS       - memory beats per line. A 64-byte line is 8 x 64-bit beats.
//   arb_state_t - states of the arbiter FSM.
//   served_t    - which requester was served most recently. It drives the
//                 round-robin choice.
package cache_pkg;

    localparam int LINE_BYTES = 64;
    localparam int BEATS      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRV_I = 1'b0,
        SRV_D = 1'b1
    } served_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one memory port between the I-cache (line fills only) and the
// D-cache (fills and writebacks). Each transaction moves one full line.
// A transaction has four phases: arbitrate, issue a command, move BEATS
// beats, then pulse done.
//
// Ports:
//   clock, reset (asynchronous, active low)
//   icache_req/addr         -> icache_grant, icache_rdata/rvalid, icache_done
//   dcache_req/we/addr/wdata -> dcache_grant, dcache_rdata/rvalid,
//                              dcache_wnext, dcache_done
//   mem_req/addr/we, mem_wdata -> memory command and write data
//   mem_ack, mem_rdata/rvalid, mem_wready <- memory responses
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = cache_pkg::BEATS
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  icache_req,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_grant,
    output logic [DATA_WIDTH-1:0] icache_rdata,
    output logic                  icache_rvalid,
    output logic                  icache_done,

    input  logic                  dcache_req,
    input  logic                  dcache_we,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [DATA_WIDTH-1:0] dcache_wdata,
    output logic                  dcache_grant,
    output logic [DATA_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_rvalid,
    output logic                  dcache_wnext,
    output logic                  dcache_done,

    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wready
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the byte-within-line offset so commands always address a whole line.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    arb_state_t            state,       state_next;
    logic                  grant_i_q,   grant_i_next;
    logic                  grant_d_q,   grant_d_next;
    logic                  mem_req_q,   mem_req_next;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_next;
    logic                  mem_we_q,    mem_we_next;
    logic [CNT_W-1:0]      beat_cnt,    beat_cnt_next;
    served_t               last_served, last_served_next;

    logic pick_i;
    logic pick_d;
    logic xfer_read;
    logic xfer_write;
    logic beat_accept;

    // Round-robin arbitration. A lone request always wins. When both
    // requests are present, the requester that was not served last wins.
    assign pick_i = icache_req && (!dcache_req || (last_served == SRV_D));
    assign pick_d = dcache_req && !pick_i;

    // Data only moves in XFER. The transfer direction comes from the
    // command that was latched when the transaction started.
    assign xfer_read   = (state == XFER) && !mem_we_q;
    assign xfer_write  = (state == XFER) &&  mem_we_q;
    assign beat_accept = (xfer_read && mem_rvalid) || (xfer_write && mem_wready);

    // State register. Reset lands in IDLE with every registered output low.
    // Last-served resets to D so that the I-cache wins the first contention.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant_i_q   <= 1'b0;
            grant_d_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            beat_cnt    <= '0;
            last_served <= SRV_D;
        end else begin
            state       <= state_next;
            grant_i_q   <= grant_i_next;
            grant_d_q   <= grant_d_next;
            mem_req_q   <= mem_req_next;
            mem_addr_q  <= mem_addr_next;
            mem_we_q    <= mem_we_next;
            beat_cnt    <= beat_cnt_next;
            last_served <= last_served_next;
        end
    end

    // Next-state logic.
    // Once a grant is made, the transaction runs to completion. While it
    // runs, new or dropped requests are ignored. Memory beat signals only
    // count while the FSM is in XFER.
    always_comb begin
        state_next       = state;
        grant_i_next     = grant_i_q;
        grant_d_next     = grant_d_q;
        mem_req_next     = mem_req_q;
        mem_addr_next    = mem_addr_q;
        mem_we_next      = mem_we_q;
        beat_cnt_next    = beat_cnt;
        last_served_next = last_served;

        case (state)
            IDLE: begin
                if (pick_i || pick_d) begin
                    state_next    = ISSUE;
                    grant_i_next  = pick_i;
                    grant_d_next  = pick_d;
                    mem_req_next  = 1'b1;
                    mem_addr_next = (pick_i ? icache_addr : dcache_addr) & LINE_MASK;
                    mem_we_next   = pick_d && dcache_we;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_next   = XFER;
                    mem_req_next = 1'b0;
                end
            end
            XFER: begin
                if (beat_accept) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        state_next    = DONE;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next       = IDLE;
                grant_i_next     = 1'b0;
                grant_d_next     = 1'b0;
                mem_addr_next    = '0;
                mem_we_next      = 1'b0;
                last_served_next = grant_i_q ? SRV_I : SRV_D;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign icache_grant = grant_i_q;
    assign dcache_grant = grant_d_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;

    // Read data passes combinationally, and only to the granted cache.
    // The other cache sees zeros.
    assign icache_rvalid = xfer_read && grant_i_q && mem_rvalid;
    assign icache_rdata  = (xfer_read && grant_i_q) ? mem_rdata : '0;
    assign dcache_rvalid = xfer_read && grant_d_q && mem_rvalid;
    assign dcache_rdata  = (xfer_read && grant_d_q) ? mem_rdata : '0;

    // Write data comes straight from the D-cache. wnext tells the D-cache
    // that memory took the current beat, so it can present the next one.
    assign mem_wdata    = xfer_write ? dcache_wdata : '0;
    assign dcache_wnext = xfer_write && grant_d_q && mem_wready;

    assign icache_done = (state == DONE) && grant_i_q;
    assign dcache_done = (state == DONE) && grant_d_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter.
// The stimulus process acts as both caches and as the memory. Each time it
// starts something, it pushes the response it expects into a queue. A
// monitor runs on the falling edge, pops the queue whenever the DUT
// presents a command, a beat or a done pulse, and compares.
module tb_cache_mem_arbiter;

    localparam int NBEATS = 8;

    typedef enum logic [2:0] {EV_CMD, EV_IRD, EV_DRD, EV_WBEAT, EV_IDONE, EV_DDONE} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [63:0] data;
        logic        we;
        logic [1:0]  grants;
    } exp_ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        icache_req = 1'b0;
    logic [63:0] icache_addr = '0;
    logic        icache_grant, icache_rvalid, icache_done;
    logic [63:0] icache_rdata;
    logic        dcache_req = 1'b0;
    logic        dcache_we = 1'b0;
    logic [63:0] dcache_addr = '0;
    logic [63:0] dcache_wdata = '0;
    logic        dcache_grant, dcache_rvalid, dcache_wnext, dcache_done;
    logic [63:0] dcache_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        mem_wready = 1'b0;

    exp_ev_t exp_q[$];
    int      tests_run = 0;
    int      tests_failed = 0;
    int      wnext_count = 0;
    logic    mem_req_prev = 1'b0;

    cache_mem_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_grant (icache_grant),
        .icache_rdata (icache_rdata),
        .icache_rvalid(icache_rvalid),
        .icache_done  (icache_done),
        .dcache_req   (dcache_req),
        .dcache_we    (dcache_we),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_grant (dcache_grant),
        .dcache_rdata (dcache_rdata),
        .dcache_rvalid(dcache_rvalid),
        .dcache_wnext (dcache_wnext),
        .dcache_done  (dcache_done),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .mem_wdata    (mem_wdata),
        .mem_wready   (mem_wready)
    );

    always #5 clock = ~clock;

    // Last-resort guard in case something unforeseen stalls the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic push_ev(input ev_kind_t kind, input logic [63:0] data, input logic we, input logic [1:0] grants);
        exp_ev_t e;
        e.kind   = kind;
        e.data   = data;
        e.we     = we;
        e.grants = grants;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t kind, input logic [63:0] data, input logic we, input logic [1:0] grants);
        exp_ev_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_event: got %s data %h we %b grants %b, expected nothing",
                     kind.name(), data, we, grants);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data || e.we !== we || e.grants !== grants) begin
                tests_failed++;
                $display("[TB] FAIL scoreboard_%s: got %s data %h we %b grants %b, expected %s data %h we %b grants %b",
                         e.kind.name(), kind.name(), data, we, grants, e.kind.name(), e.data, e.we, e.grants);
            end
        end
    endtask

    // Monitor: checks the exclusivity invariants every cycle and matches
    // each observable DUT event against the head of the scoreboard queue.
    always @(negedge clock) begin
        if (!reset) begin
            mem_req_prev = 1'b0;
        end else begin
            check_output("single_grant", 64'(icache_grant & dcache_grant), 64'd0);
            check_output("single_done", 64'(icache_done & dcache_done), 64'd0);
            if (mem_req && !mem_req_prev)
                observe(EV_CMD, mem_addr, mem_we, {icache_grant, dcache_grant});
            if (icache_rvalid) begin
                observe(EV_IRD, icache_rdata, 1'b0, 2'b00);
                check_output("d_rdata_quiet", dcache_rdata, 64'd0);
            end
            if (dcache_rvalid) begin
                observe(EV_DRD, dcache_rdata, 1'b0, 2'b00);
                check_output("i_rdata_quiet", icache_rdata, 64'd0);
            end
            if (dcache_wnext) begin
                observe(EV_WBEAT, mem_wdata, 1'b0, 2'b00);
                wnext_count++;
            end
            if (icache_done) observe(EV_IDONE, 64'd0, 1'b0, 2'b00);
            if (dcache_done) observe(EV_DDONE, 64'd0, 1'b0, 2'b00);
            mem_req_prev = mem_req;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic i_req, input logic [63:0] i_addr, input logic d_req,
                                  input logic d_we, input logic [63:0] d_addr);
        icache_req  = i_req;
        icache_addr = i_addr;
        dcache_req  = d_req;
        dcache_we   = d_we;
        dcache_addr = d_addr;
    endtask

    task automatic wait_mem_req();
        int waited;
        waited = 0;
        while (mem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check_output("mem_req_raised", 64'(mem_req), 64'd1);
    endtask

    // Plays the memory side of a line fill. The ack can be held off for
    // ack_delay cycles, and a stray rvalid can be injected during ISSUE.
    // Then n_beats beats are returned. Returns one step after the last
    // accepted beat, which is the DONE cycle for a complete burst.
    task automatic serve_read(input bit to_i, input logic [63:0] exp_addr, input int ack_delay,
                              input int stray_cycle, input int n_beats, input logic [63:0] base);
        wait_mem_req();
        for (int c = 0; c < ack_delay; c++) begin
            check_output("issue_req_stable", 64'(mem_req), 64'd1);
            check_output("issue_addr_stable", mem_addr, exp_addr);
            if (c == stray_cycle) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 64'hDEAD_BEEF_0000_0001;
                #1;
                check_output("stray_not_forwarded", 64'({icache_rvalid, dcache_rvalid}), 64'd0);
            end
            tick();
            mem_rvalid = 1'b0;
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_output("req_drop_after_ack", 64'(mem_req), 64'd0);
        for (int k = 0; k < n_beats; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 64'(k);
            push_ev(to_i ? EV_IRD : EV_DRD, base + 64'(k), 1'b0, 2'b00);
            tick();
        end
        mem_rvalid = 1'b0;
        if (n_beats == NBEATS) begin
            push_ev(to_i ? EV_IDONE : EV_DDONE, 64'd0, 1'b0, 2'b00);
            check_output("done_after_last_beat", 64'(to_i ? icache_done : dcache_done), 64'd1);
        end
    endtask

    // Plays the memory side of a writeback. wready is held low for one
    // cycle in front of beats 3 and 5.
    task automatic serve_write(input logic [63:0] exp_addr, input logic [63:0] base);
        wait_mem_req();
        check_output("wb_addr", mem_addr, exp_addr);
        check_output("wb_we", 64'(mem_we), 64'd1);
        check_output("wdata_zero_in_issue", mem_wdata, 64'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < NBEATS; k++) begin
            dcache_wdata = base + 64'(k);
            if (k == 2 || k == 4) begin
                mem_wready = 1'b0;
                #1;
                check_output("wdata_tracks_on_stall", mem_wdata, base + 64'(k));
                check_output("no_wnext_on_stall", 64'(dcache_wnext), 64'd0);
                tick();
            end
            mem_wready = 1'b1;
            push_ev(EV_WBEAT, base + 64'(k), 1'b0, 2'b00);
            tick();
        end
        mem_wready = 1'b0;
        push_ev(EV_DDONE, 64'd0, 1'b0, 2'b00);
        check_output("wb_done_after_last_beat", 64'(dcache_done), 64'd1);
    endtask

    initial begin
        // Reset state.
        #3;
        check_output("rst_icache_grant", 64'(icache_grant), 64'd0);
        check_output("rst_dcache_grant", 64'(dcache_grant), 64'd0);
        check_output("rst_mem_req", 64'(mem_req), 64'd0);
        check_output("rst_mem_addr", mem_addr, 64'd0);
        check_output("rst_mem_we", 64'(mem_we), 64'd0);
        check_output("rst_done", 64'({icache_done, dcache_done}), 64'd0);
        check_output("rst_rvalid", 64'({icache_rvalid, dcache_rvalid, dcache_wnext}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Both caches request in the same cycle, straight out of reset. The
        // I-cache wins. The D fill is granted two cycles after icache_done.
        push_ev(EV_CMD, 64'h40, 1'b0, 2'b10);
        apply_stimulus(1'b1, 64'h40, 1'b1, 1'b0, 64'h8040);
        tick();
        check_output("contend_i_granted", 64'(icache_grant), 64'd1);
        check_output("contend_d_waits", 64'(dcache_grant), 64'd0);
        serve_read(1'b1, 64'h40, 0, -1, NBEATS, 64'hA000_0000_0000_0000);
        icache_req = 1'b0;
        push_ev(EV_CMD, 64'h8040, 1'b0, 2'b01);
        tick();
        check_output("i_done_single_pulse", 64'(icache_done), 64'd0);
        check_output("d_grant_not_yet", 64'(dcache_grant), 64'd0);
        tick();
        check_output("d_grant_two_after_done", 64'(dcache_grant), 64'd1);
        serve_read(1'b0, 64'h8040, 0, -1, NBEATS, 64'hB000_0000_0000_0000);
        dcache_req = 1'b0;
        tick();
        check_output("d_grant_cleared", 64'(dcache_grant), 64'd0);

        // I-cache fill on its own. The address is aligned down to the line.
        push_ev(EV_CMD, 64'h1200, 1'b0, 2'b10);
        apply_stimulus(1'b1, 64'h1234, 1'b0, 1'b0, 64'h0);
        tick();
        check_output("i_grant_latency", 64'(icache_grant), 64'd1);
        serve_read(1'b1, 64'h1200, 0, -1, NBEATS, 64'hC000_0000_0000_0000);
        icache_req = 1'b0;
        tick();
        check_output("i_only_done_single", 64'(icache_done), 64'd0);

        // D-cache writeback with wready stalls in front of beats 3 and 5.
        wnext_count = 0;
        push_ev(EV_CMD, 64'hFFC0, 1'b1, 2'b01);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'hFFC0);
        dcache_wdata = 64'hD000_0000_0000_0000;
        tick();
        check_output("wb_grant", 64'(dcache_grant), 64'd1);
        serve_write(64'hFFC0, 64'hD000_0000_0000_0000);
        dcache_req = 1'b0;
        dcache_we  = 1'b0;
        tick();
        check_output("wb_wnext_count", 64'(wnext_count), 64'd8);

        // The ack is held off for 5 cycles, with a stray rvalid during ISSUE.
        push_ev(EV_CMD, 64'h20A80, 1'b0, 2'b10);
        apply_stimulus(1'b1, 64'h20ABC, 1'b0, 1'b0, 64'h0);
        tick();
        serve_read(1'b1, 64'h20A80, 5, 2, NBEATS, 64'hE000_0000_0000_0000);
        icache_req = 1'b0;
        tick();

        // Reset hits mid-burst, after beat 4, while beat 5 is on the bus.
        push_ev(EV_CMD, 64'h3000, 1'b0, 2'b10);
        apply_stimulus(1'b1, 64'h3000, 1'b0, 1'b0, 64'h0);
        tick();
        serve_read(1'b1, 64'h3000, 0, -1, 4, 64'hF000_0000_0000_0000);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hF000_0000_0000_0004;
        #1;
        reset = 1'b0;
        #1;
        check_output("midrst_grants", 64'({icache_grant, dcache_grant}), 64'd0);
        check_output("midrst_rvalid", 64'({icache_rvalid, dcache_rvalid}), 64'd0);
        check_output("midrst_rdata", icache_rdata, 64'd0);
        check_output("midrst_mem_req", 64'(mem_req), 64'd0);
        check_output("midrst_mem_addr", mem_addr, 64'd0);
        check_output("midrst_done", 64'({icache_done, dcache_done}), 64'd0);
        exp_q.delete();
        icache_req = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // After reset, a fresh fill runs a full 8 beats. The two caches
        // contend again, and I wins because last-served is back to D.
        push_ev(EV_CMD, 64'h5040, 1'b0, 2'b10);
        apply_stimulus(1'b1, 64'h5040, 1'b1, 1'b0, 64'h6000);
        tick();
        check_output("post_rst_i_granted", 64'(icache_grant), 64'd1);
        serve_read(1'b1, 64'h5040, 0, -1, NBEATS, 64'h5000_0000_0000_0000);
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        tick();
        tick();

        check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
